priority_exception_unit: RTL and testbench
==========================================

PRIORITY_EXCEPTION_UNIT -- requirements
Module: priority_exception_unit

Interface
REQ-001 Parameter NUM_EXC, default 16: number of synchronous exception sources, 2..32.
REQ-002 Parameter IRQ_W, default 4: width of the external interrupt identifier.
REQ-003 Parameter CAUSE_W, default 5: cause width; SHALL satisfy 2^CAUSE_W >= NUM_EXC + 2^IRQ_W, else elaboration error.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 triggerException  input  NUM_EXC: per-source exception pulses, bit i = source i.
REQ-007 exceptionMask  input  NUM_EXC: 1 = source enabled.
REQ-008 interruptEnable  input  1: global external interrupt enable.
REQ-009 interruptRequest  input  1: level request from interrupt controller.
REQ-010 interruptIn  input  IRQ_W: identifier accompanying interruptRequest.
REQ-011 takeException  input  1: one-cycle strobe from controller at instruction boundary, accepting the highest-priority pending event.
REQ-012 exceptionPending  output  1: some enabled exception latched.
REQ-013 interruptPending  output  1: an external interrupt captured and awaiting take.
REQ-014 cause  output  CAUSE_W: cause of last taken event.
REQ-015 interruptOut  output  IRQ_W: identifier of the acknowledged interrupt.
REQ-016 interruptAcknowledge  output  1: one-cycle acknowledge pulse.
REQ-017 overrun  output  1: sticky flag, source retriggered while already pending.

Function
REQ-018 A registered pending vector SHALL set bit i the cycle after triggerException[i]=1, independent of mask.
REQ-019 exceptionPending SHALL equal OR of (pending AND exceptionMask), combinational from registers; masked bits stay latched and assert when unmasked.
REQ-020 Priority: lowest enabled pending index wins; any exception beats any interrupt.
REQ-021 On takeException with exceptionPending=1: cause <= winning index (zero-extended), that pending bit cleared, next cycle.
REQ-022 Same-cycle trigger and take-clear of the same bit: set wins, bit remains pending.
REQ-023 triggerException[i]=1 while pending[i]=1 SHALL set overrun; only reset clears it.
REQ-024 Interrupt FSM states IDLE, CAPTURED, ACK, WAIT_DROP; reset to IDLE.
REQ-025 IDLE->CAPTURED when interruptRequest=1 and interruptEnable=1; interruptIn latched into internal ID register.
REQ-026 interruptPending=1 only in CAPTURED; interruptEnable dropping in CAPTURED SHALL return to IDLE without ack.
REQ-027 CAPTURED->ACK on takeException with exceptionPending=0: cause <= NUM_EXC + latched ID; interruptOut <= latched ID.
REQ-028 ACK lasts exactly one cycle with interruptAcknowledge=1, then WAIT_DROP.
REQ-029 WAIT_DROP->IDLE when interruptRequest=0; no new capture before that.
REQ-030 takeException with nothing pending SHALL be ignored; cause, pending, FSM unchanged.
REQ-031 interruptOut SHALL hold its value until the next ACK.

Reset
REQ-032 During reset: pending=0, overrun=0, cause=0, interruptOut=0, interruptAcknowledge=0, FSM=IDLE; reset mid-handshake aborts with no ack pulse.
REQ-033 Outputs derived from state SHALL be valid the first edge after reset deasserts; no synchronous reset paths.

Verification
REQ-034 Pulse trigger bits 3 and 1, mask all ones, two takes -> cause 1 then 3; exceptionPending 0 after second take.
REQ-035 Trigger bit 2 with mask bit 2=0 -> exceptionPending 0; set mask bit 2 -> exceptionPending 1, take -> cause 2.
REQ-036 interruptRequest=1, interruptIn=0x9, enable=1, take -> cause 25 (NUM_EXC=16), interruptOut 0x9, one-cycle ack, no recapture until request drops.
REQ-037 Interrupt captured plus exception bit 5 pending, take -> cause 5, interruptPending stays 1; second take -> interrupt acked.
REQ-038 Trigger bit 0 twice without take -> overrun 1; trigger bit 4 same cycle as its take -> bit 4 still pending.
REQ-039 Assert reset in ACK state -> interruptAcknowledge 0 immediately, all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/priority_exception_unit.sv
// Exception/interrupt prioritiser: latches per-source exceptions, captures one external
// interrupt, and reports the cause of whichever event the controller takes.
module priority_exception_unit #(
  parameter int unsigned NUM_EXC = 16,
  parameter int unsigned IRQ_W   = 4,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXC-1:0] triggerException,
  input  logic [NUM_EXC-1:0] exceptionMask,
  input  logic               interruptEnable,
  input  logic               interruptRequest,
  input  logic [IRQ_W-1:0]   interruptIn,
  input  logic               takeException,
  output logic               exceptionPending,
  output logic               interruptPending,
  output logic [CAUSE_W-1:0] cause,
  output logic [IRQ_W-1:0]   interruptOut,
  output logic               interruptAcknowledge,
  output logic               overrun
);

  localparam int unsigned IDX_W = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;

  generate
    if (NUM_EXC < 2 || NUM_EXC > 32) begin : g_bad_num_exc
      $error("NUM_EXC must be in 2..32");
    end
    if ((2 ** CAUSE_W) < (NUM_EXC + (2 ** IRQ_W))) begin : g_bad_cause_w
      $error("CAUSE_W too narrow for NUM_EXC exceptions plus all interrupt ids");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CAPTURED  = 2'd1,
    S_ACK       = 2'd2,
    S_WAIT_DROP = 2'd3
  } state_t;

  state_t               r_state;
  logic [NUM_EXC-1:0]   r_pending;
  logic                 r_overrun;
  logic [CAUSE_W-1:0]   r_cause;
  logic [IRQ_W-1:0]     r_irq_id;
  logic [IRQ_W-1:0]     r_irq_out;
  logic                 r_ack;

  logic [NUM_EXC-1:0]   w_enabled;
  logic                 w_exc_pending;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_take_exc;
  logic [NUM_EXC-1:0]   w_clear;

  assign w_enabled     = r_pending & exceptionMask;
  assign w_exc_pending = |w_enabled;
  assign w_take_exc    = takeException & w_exc_pending;
  assign w_clear       = w_take_exc ? (NUM_EXC'(1) << w_winner) : '0;

  // Lowest enabled pending index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    w_winner = '0;
    for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
      if (w_enabled[i]) w_winner = IDX_W'(i);
    end
  end

  // A trigger arriving with the take-clear of the same bit keeps it pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | triggerException;
      if (|(triggerException & r_pending)) r_overrun <= 1'b1;
    end
  end

  // Interrupt handshake and cause reporting; exceptions always beat the interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_irq_id  <= '0;
      r_irq_out <= '0;
      r_cause   <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_take_exc) r_cause <= CAUSE_W'(w_winner);
      case (r_state)
        S_IDLE: begin
          if (interruptRequest && interruptEnable) begin
            r_state  <= S_CAPTURED;
            r_irq_id <= interruptIn;
          end
        end
        S_CAPTURED: begin
          if (!interruptEnable) begin
            r_state <= S_IDLE;
          end else if (takeException && !w_exc_pending) begin
            r_state   <= S_ACK;
            r_cause   <= CAUSE_W'(NUM_EXC) + CAUSE_W'(r_irq_id);
            r_irq_out <= r_irq_id;
            r_ack     <= 1'b1;
          end
        end
        S_ACK:       r_state <= S_WAIT_DROP;
        S_WAIT_DROP: if (!interruptRequest) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign exceptionPending     = w_exc_pending;
  assign interruptPending     = (r_state == S_CAPTURED);
  assign cause                = r_cause;
  assign interruptOut         = r_irq_out;
  assign interruptAcknowledge = r_ack;
  assign overrun              = r_overrun;

endmodule

// File: tb/tb_priority_exception_unit.sv
// Directed and randomized checks of priority_exception_unit against a behavioural model.
module tb_priority_exception_unit;

  localparam int NEXC = 16;

  logic        clk;
  logic        reset;
  logic [15:0] trig;
  logic [15:0] mask;
  logic        en;
  logic        req;
  logic [3:0]  irq_in;
  logic        take;
  logic        exc_pend;
  logic        int_pend;
  logic [4:0]  cause;
  logic [3:0]  irq_out;
  logic        ack;
  logic        ovr;

  int tests;
  int failed;

  // Model: pending set, sticky overrun, last cause, and the interrupt's handshake phase.
  localparam int PH_IDLE = 0, PH_HELD = 1, PH_ACKED = 2, PH_DROP = 3;
  logic [15:0] m_pend;
  logic        m_ovr;
  logic [4:0]  m_cause;
  logic [3:0]  m_iout;
  logic [3:0]  m_id;
  logic        m_ack;
  int          m_phase;

  priority_exception_unit #(.NUM_EXC(16), .IRQ_W(4), .CAUSE_W(5)) dut (
    .clk(clk), .reset(reset),
    .triggerException(trig), .exceptionMask(mask),
    .interruptEnable(en), .interruptRequest(req), .interruptIn(irq_in),
    .takeException(take),
    .exceptionPending(exc_pend), .interruptPending(int_pend),
    .cause(cause), .interruptOut(irq_out),
    .interruptAcknowledge(ack), .overrun(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_ovr = 1'b0; m_cause = '0; m_iout = '0; m_id = '0;
    m_ack = 1'b0; m_phase = PH_IDLE;
  endtask

  task automatic model_update();
    int win;
    logic [15:0] live;
    live = m_pend & mask;
    win = -1;
    for (int i = 0; i < NEXC; i++) if (live[i] && win < 0) win = i;
    if ((trig & m_pend) != 16'h0) m_ovr = 1'b1;
    if (take && win >= 0) begin
      m_cause = 5'(win);
      m_pend[win] = 1'b0;
    end
    m_pend = m_pend | trig;
    m_ack = 1'b0;
    case (m_phase)
      PH_IDLE: if (req && en) begin m_phase = PH_HELD; m_id = irq_in; end
      PH_HELD: begin
        if (!en) m_phase = PH_IDLE;
        else if (take && win < 0) begin
          m_phase = PH_ACKED;
          m_cause = 5'(NEXC + int'(m_id));
          m_iout = m_id;
          m_ack = 1'b1;
        end
      end
      PH_ACKED: m_phase = PH_DROP;
      default:  if (!req) m_phase = PH_IDLE;
    endcase
  endtask

  // One clock: advance the model with the current inputs, then settle past the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trig = '0; take = 1'b0; req = 1'b0; en = 1'b1; irq_in = '0; mask = 16'hFFFF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({exc_pend, int_pend, cause, irq_out, ack, ovr} !== 13'h0) begin
      failed++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {exc_pend, int_pend, cause, irq_out, ack, ovr});
    end
    @(negedge clk);
    reset = 1'b0;
    #4;
  endtask

  task automatic test_priority();
    trig = 16'h000A; step();
    trig = '0;
    tests++;
    if (exc_pend !== 1'b1) begin failed++; $display("FAIL prio_pending: got %b expected 1", exc_pend); end
    take = 1'b1; step();
    tests++;
    if (cause !== 5'd1) begin failed++; $display("FAIL prio_first_cause: got %0d expected 1", cause); end
    step();
    take = 1'b0;
    tests++;
    if (cause !== 5'd3) begin failed++; $display("FAIL prio_second_cause: got %0d expected 3", cause); end
    tests++;
    if (exc_pend !== 1'b0) begin failed++; $display("FAIL prio_drained: got %b expected 0", exc_pend); end
  endtask

  task automatic test_mask();
    mask = 16'hFFFB; trig = 16'h0004; step();
    trig = '0; #1;
    tests++;
    if (exc_pend !== 1'b0) begin failed++; $display("FAIL mask_hidden: got %b expected 0", exc_pend); end
    take = 1'b1; step();
    take = 1'b0;
    tests++;
    if (cause !== 5'd3) begin failed++; $display("FAIL mask_ignored_take: cause got %0d expected 3", cause); end
    mask = 16'hFFFF; #1;
    tests++;
    if (exc_pend !== 1'b1) begin failed++; $display("FAIL mask_unmasked: got %b expected 1", exc_pend); end
    take = 1'b1; step();
    take = 1'b0;
    tests++;
    if (cause !== 5'd2) begin failed++; $display("FAIL mask_cause: got %0d expected 2", cause); end
  endtask

  task automatic test_interrupt();
    req = 1'b1; irq_in = 4'h9; step();
    irq_in = 4'h3;
    tests++;
    if (int_pend !== 1'b1) begin failed++; $display("FAIL irq_captured: got %b expected 1", int_pend); end
    take = 1'b1; step();
    take = 1'b0;
    tests++;
    if ({cause, irq_out, ack} !== {5'd25, 4'h9, 1'b1}) begin
      failed++;
      $display("FAIL irq_ack: cause=%0d out=%h ack=%b expected 25 9 1", cause, irq_out, ack);
    end
    step();
    tests++;
    if ({ack, int_pend} !== 2'b00) begin failed++; $display("FAIL irq_ack_width: ack=%b pend=%b expected 0 0", ack, int_pend); end
    repeat (3) step();
    tests++;
    if (int_pend !== 1'b0) begin failed++; $display("FAIL irq_no_recapture: got %b expected 0", int_pend); end
    req = 1'b0; step();
    req = 1'b1; step();
    tests++;
    if (int_pend !== 1'b1) begin failed++; $display("FAIL irq_recapture: got %b expected 1", int_pend); end
    en = 1'b0; step();
    tests++;
    if ({int_pend, ack, irq_out} !== {1'b0, 1'b0, 4'h9}) begin
      failed++;
      $display("FAIL irq_enable_drop: pend=%b ack=%b out=%h expected 0 0 9", int_pend, ack, irq_out);
    end
    req = 1'b0; en = 1'b1; step();
  endtask

  task automatic test_exc_beats_irq();
    req = 1'b1; irq_in = 4'h6; trig = 16'h0020; step();
    trig = '0;
    take = 1'b1; step();
    take = 1'b0;
    tests++;
    if ({cause, int_pend, ack} !== {5'd5, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL exc_first: cause=%0d pend=%b ack=%b expected 5 1 0", cause, int_pend, ack);
    end
    take = 1'b1; step();
    take = 1'b0;
    tests++;
    if ({cause, irq_out, ack} !== {5'd22, 4'h6, 1'b1}) begin
      failed++;
      $display("FAIL irq_second: cause=%0d out=%h ack=%b expected 22 6 1", cause, irq_out, ack);
    end
    req = 1'b0; step(); step();
  endtask

  task automatic test_overrun_set_wins();
    tests++;
    if (ovr !== 1'b0) begin failed++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
    trig = 16'h0001; step();
    step();
    trig = '0;
    tests++;
    if (ovr !== 1'b1) begin failed++; $display("FAIL ovr_set: got %b expected 1", ovr); end
    take = 1'b1; step();
    take = 1'b0;
    trig = 16'h0010; step();
    take = 1'b1; step();
    trig = '0; take = 1'b0;
    tests++;
    if ({cause, exc_pend} !== {5'd4, 1'b1}) begin
      failed++;
      $display("FAIL set_wins: cause=%0d pend=%b expected 4 1", cause, exc_pend);
    end
    take = 1'b1; step();
    take = 1'b0;
    tests++;
    if ({exc_pend, ovr} !== 2'b01) begin failed++; $display("FAIL set_wins_drain: pend=%b ovr=%b expected 0 1", exc_pend, ovr); end
    step();
    tests++;
    if (cause !== 5'd4) begin failed++; $display("FAIL empty_take: cause got %0d expected 4", cause); end
  endtask

  task automatic test_reset_in_ack();
    trig = 16'h0100; req = 1'b1; irq_in = 4'hC; step();
    trig = '0; take = 1'b1; step();
    step();
    take = 1'b0;
    tests++;
    if (ack !== 1'b1) begin failed++; $display("FAIL pre_reset_ack: got %b expected 1", ack); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    tests++;
    if ({exc_pend, int_pend, cause, irq_out, ack, ovr} !== 13'h0) begin
      failed++;
      $display("FAIL reset_in_ack: got %b expected all zero",
               {exc_pend, int_pend, cause, irq_out, ack, ovr});
    end
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    #4;
    step();
    tests++;
    if ({int_pend, ack} !== 2'b00) begin failed++; $display("FAIL post_reset_idle: pend=%b ack=%b expected 0 0", int_pend, ack); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      trig   = ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'($urandom) : 16'h0;
      mask   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : mask;
      take   = ($urandom_range(0, 2) == 0);
      en     = ($urandom_range(0, 7) != 0);
      req    = ($urandom_range(0, 3) == 0) ? ~req : req;
      irq_in = 4'($urandom);
      step();
      tests++;
      if (exc_pend !== |(m_pend & mask)) begin failed++; $display("FAIL rnd_exc_pend[%0d]: got %b expected %b", n, exc_pend, |(m_pend & mask)); end
      tests++;
      if (int_pend !== (m_phase == PH_HELD)) begin failed++; $display("FAIL rnd_int_pend[%0d]: got %b expected %b", n, int_pend, m_phase == PH_HELD); end
      tests++;
      if (cause !== m_cause) begin failed++; $display("FAIL rnd_cause[%0d]: got %0d expected %0d", n, cause, m_cause); end
      tests++;
      if (irq_out !== m_iout) begin failed++; $display("FAIL rnd_irq_out[%0d]: got %h expected %h", n, irq_out, m_iout); end
      tests++;
      if (ack !== m_ack) begin failed++; $display("FAIL rnd_ack[%0d]: got %b expected %b", n, ack, m_ack); end
      tests++;
      if (ovr !== m_ovr) begin failed++; $display("FAIL rnd_overrun[%0d]: got %b expected %b", n, ovr, m_ovr); end
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_priority();
    test_mask();
    test_interrupt();
    test_exc_beats_irq();
    test_overrun_set_wins();
    test_reset_in_ack();
    idle_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
